// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the 5-stage pipeline sequencer: sequencer state
// encodings, register-address width and the default drain timeout.
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_WIDTH    = 5;
  localparam int DRAIN_MAX_DEFAULT = 7;

  typedef enum logic [2:0] {
    PCTRL_IDLE   = 3'd0,
    PCTRL_RUN    = 3'd1,
    PCTRL_STEP   = 3'd2,
    PCTRL_DRAIN  = 3'd3,
    PCTRL_HALTED = 3'd4
  } pctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use compare between the load in EX and the
// source registers of the instruction in ID.
//   ex_mem_read  in  load in EX (mem_read_out of ID/EX)
//   ex_rt        in  destination of that load (rt_out of ID/EX)
//   id_rs/id_rt  in  source registers of the instruction in ID
//   id_uses_rt   in  ID instruction actually reads rt
//   load_use     out one-cycle stall required
// -----------------------------------------------------------------------------
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_uses_rt,
  output logic                      load_use
);

  // A load into $zero never produces a value, so it cannot create a hazard.
  always_comb begin
    load_use = ex_mem_read && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Central sequencer of the 5-stage MIPS pipeline. Owns run/step/halt state,
// drives PC and IF/ID enables, IF/ID and ID/EX flushes, inserts load-use
// bubbles, applies mispredict flushes and drains the pipe on HALT.
// ID/EX has no enable, so every bubble goes through id_ex_flush.
//   clk, reset          clock, synchronous active-high reset
//   start, step_mode    debug-unit launch (step_mode sampled with start)
//   id_rs/id_rt/id_uses_rt/id_is_halt   decode info of the ID instruction
//   ex_mem_read, ex_rt  load info of the EX instruction
//   mispredict          branch resolution disagrees with fetch path
//   wb_is_halt          HALT has reached WB
//   pc_write, if_id_write, if_id_flush, id_ex_flush   pipeline controls
//   halted, drain_err   status (drain_err is sticky until reset)
//   cycle_count, stall_count   wrapping performance counters
// -----------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int DRAIN_MAX = DRAIN_MAX_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      step_mode,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_uses_rt,
  input  logic                      id_is_halt,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
  input  logic                      mispredict,
  input  logic                      wb_is_halt,
  output logic                      pc_write,
  output logic                      if_id_write,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      halted,
  output logic                      drain_err,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [CNT_W-1:0]          stall_count
);

  localparam int DCNT_W = $clog2(DRAIN_MAX + 1);
  // Value of the drain counter during the last permitted DRAIN cycle.
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_MAX - 1);

  pctrl_state_e      state_q, state_d;
  logic [DCNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic              drain_err_q, drain_err_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              load_use;

  hazard_detect u_hazard (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .load_use    (load_use)
  );

  // NOTE: reset is sampled only on the clock edge, and all state uses
  // non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PCTRL_IDLE;
      drain_cnt_q <= '0;
      drain_err_q <= 1'b0;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      drain_err_q <= drain_err_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = '0;  // only accumulates while in DRAIN
    drain_err_d = drain_err_q;
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    // Safe "pipeline frozen" controls: nothing advances, EX gets a bubble.
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b1;

    unique case (state_q)
      PCTRL_IDLE: begin
        if (start) state_d = step_mode ? PCTRL_STEP : PCTRL_RUN;
      end

      PCTRL_RUN, PCTRL_STEP: begin
        cycle_cnt_d = cycle_cnt_q + 1'b1;
        // A single step is spent whatever this cycle does, unless HALT
        // is accepted below and the pipe has to drain.
        if (state_q == PCTRL_STEP) state_d = PCTRL_IDLE;

        if (mispredict) begin
          // Redirect fetch and squash both wrong-path instructions; a HALT
          // sitting in ID is on the wrong path and is dropped.
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end else if (id_is_halt) begin
          // Let HALT itself move into EX, stop fetching behind it.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b0;
          state_d     = PCTRL_DRAIN;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          id_ex_flush = 1'b0;
        end
      end

      PCTRL_DRAIN: begin
        cycle_cnt_d = cycle_cnt_q + 1'b1;
        if (wb_is_halt) begin
          state_d = PCTRL_HALTED;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          drain_err_d = 1'b1;
          state_d     = PCTRL_HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end

      PCTRL_HALTED: begin
        // Terminal until reset.
      end

      default: state_d = PCTRL_IDLE;
    endcase
  end

  assign halted      = (state_q == PCTRL_HALTED);
  assign drain_err   = drain_err_q;
  assign cycle_count = cycle_cnt_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Scenario bench for pipeline_ctrl. Each scenario builds a per-cycle table of
// inputs and expected controls; expected values go into a scoreboard queue
// when the cycle is driven and are popped and compared on the falling edge.
// Control vector layout: {pc_write, if_id_write, if_id_flush, id_ex_flush,
// halted, drain_err}. A mask drops bits the design leaves open.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int CNT_W = 32;

  localparam logic [5:0] O_IDLE   = 6'b000100;
  localparam logic [5:0] O_RUN    = 6'b110000;
  localparam logic [5:0] O_STALL  = 6'b000100;
  localparam logic [5:0] O_MIS    = 6'b111100;
  localparam logic [5:0] O_HALTID = 6'b001000;
  localparam logic [5:0] O_DRAIN  = 6'b000100;
  localparam logic [5:0] O_HALTED = 6'b000110;
  localparam logic [5:0] O_HERR   = 6'b000111;

  localparam logic [5:0] M_ALL    = 6'b111111;
  localparam logic [5:0] M_STALL  = 6'b110111;  // if_id_flush open
  localparam logic [5:0] M_HID    = 6'b101111;  // if_id_write open
  localparam logic [5:0] M_DRAIN  = 6'b110111;  // if_id_flush open

  logic clk, reset, start, step_mode, id_uses_rt, id_is_halt;
  logic ex_mem_read, mispredict, wb_is_halt;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, halted, drain_err;
  logic [CNT_W-1:0] cycle_count, stall_count;

  typedef struct {
    string      name;
    logic       start, step, mrd;
    logic [4:0] ex_rt, id_rs, id_rt;
    logic       uses, halt, mis, wb, rst;
    logic [5:0] exp, msk;
    bit         act, stl;
  } stim_t;

  typedef struct {
    string            name;
    logic [5:0]       exp, msk;
    logic [CNT_W-1:0] cyc, stl;
  } sb_t;

  sb_t              sb_q[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_cyc = '0;
  logic [CNT_W-1:0] exp_stl = '0;

  pipeline_ctrl #(.CNT_W(CNT_W), .DRAIN_MAX(7)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .step_mode   (step_mode),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .id_is_halt  (id_is_halt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .mispredict  (mispredict),
    .wb_is_halt  (wb_is_halt),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .halted      (halted),
    .drain_err   (drain_err),
    .cycle_count (cycle_count),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {pc_write, if_id_write, if_id_flush, id_ex_flush, halted, drain_err};
  endfunction

  // Argument order: name, start, step, mem_read, ex_rt, id_rs, id_rt,
  // uses_rt, id_halt, mispredict, wb_halt, reset, exp, mask, active, stall.
  function automatic stim_t mk(string name, logic st, logic sm, logic mrd,
                               logic [4:0] xrt, logic [4:0] rs, logic [4:0] rt,
                               logic uses, logic hlt, logic mis, logic wb, logic rst,
                               logic [5:0] exp, logic [5:0] msk, bit act, bit stl);
    stim_t s;
    s.name = name; s.start = st; s.step = sm; s.mrd = mrd;
    s.ex_rt = xrt; s.id_rs = rs; s.id_rt = rt; s.uses = uses;
    s.halt = hlt; s.mis = mis; s.wb = wb; s.rst = rst;
    s.exp = exp; s.msk = msk; s.act = act; s.stl = stl;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    reset       = s.rst;
    start       = s.start;
    step_mode   = s.step;
    ex_mem_read = s.mrd;
    ex_rt       = s.ex_rt;
    id_rs       = s.id_rs;
    id_rt       = s.id_rt;
    id_uses_rt  = s.uses;
    id_is_halt  = s.halt;
    mispredict  = s.mis;
    wb_is_halt  = s.wb;
  endtask

  // Scoreboard bookkeeping on drive: counters expected this cycle are the
  // totals of all earlier cycles; this cycle's contribution lands on the edge.
  task automatic push_exp(input stim_t s);
    sb_q.push_back('{s.name, s.exp, s.msk, exp_cyc, exp_stl});
    if (s.rst) begin
      exp_cyc = '0;
      exp_stl = '0;
    end else begin
      exp_cyc = exp_cyc + CNT_W'(s.act);
      exp_stl = exp_stl + CNT_W'(s.stl);
    end
  endtask

  task automatic test_reset();
    sb_t e;
    reset = 1'b1;
    start = 1'b1; step_mode = 1'($urandom); ex_mem_read = 1'b1;
    ex_rt = 5'd9; id_rs = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
    id_is_halt = 1'b1; mispredict = 1'b1; wb_is_halt = 1'b1;
    exp_cyc = '0;
    exp_stl = '0;
    repeat (2) @(posedge clk);
    sb_q.push_back('{"reset", O_IDLE, M_ALL, exp_cyc, exp_stl});
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if (outs() !== e.exp) begin
      errors++;
      $display("FAIL %s ctrl got %b want %b", e.name, outs(), e.exp);
    end
    checks++;
    if (cycle_count !== e.cyc || stall_count !== e.stl) begin
      errors++;
      $display("FAIL %s counters got cyc=%0d stl=%0d want 0/0", e.name, cycle_count, stall_count);
    end
    @(posedge clk); #1;
    apply(mk("rel", 0,0,0, 0,0,0, 0,0,0,0,0, O_IDLE, M_ALL, 0,0));
  endtask

  task automatic test_idle();
    stim_t t[$];
    sb_t   e;
    repeat (5) t.push_back(mk("idle_hold", 0,0,0, 0,0,0, 0,0,0,0,0, O_IDLE, M_ALL, 0,0));
    foreach (t[i]) begin
      apply(t[i]); push_exp(t[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ((outs() & e.msk) !== (e.exp & e.msk)) begin
        errors++;
        $display("FAIL %s ctrl got %b want %b mask %b", e.name, outs(), e.exp, e.msk);
      end
      checks++;
      if (cycle_count !== e.cyc || stall_count !== e.stl) begin
        errors++;
        $display("FAIL %s counters got cyc=%0d stl=%0d want cyc=%0d stl=%0d",
                 e.name, cycle_count, stall_count, e.cyc, e.stl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t t[$];
    sb_t   e;
    t.push_back(mk("lu_start",     1,0,0, 0,0,0, 0,0,0,0,0, O_IDLE,  M_ALL,   0,0));
    t.push_back(mk("lu_stall_rs",  0,0,1, 5,5,0, 0,0,0,0,0, O_STALL, M_STALL, 1,1));
    t.push_back(mk("lu_resume",    0,0,0, 0,0,0, 0,0,0,0,0, O_RUN,   M_ALL,   1,0));
    t.push_back(mk("lu_r0",        0,0,1, 0,0,0, 1,0,0,0,0, O_RUN,   M_ALL,   1,0));
    t.push_back(mk("lu_stall_rt",  0,0,1, 7,3,7, 1,0,0,0,0, O_STALL, M_STALL, 1,1));
    t.push_back(mk("lu_rt_unused", 0,0,1, 7,3,7, 0,0,0,0,0, O_RUN,   M_ALL,   1,0));
    t.push_back(mk("lu_no_read",   0,0,0, 5,5,5, 1,0,0,0,0, O_RUN,   M_ALL,   1,0));
    foreach (t[i]) begin
      apply(t[i]); push_exp(t[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ((outs() & e.msk) !== (e.exp & e.msk)) begin
        errors++;
        $display("FAIL %s ctrl got %b want %b mask %b", e.name, outs(), e.exp, e.msk);
      end
      checks++;
      if (cycle_count !== e.cyc || stall_count !== e.stl) begin
        errors++;
        $display("FAIL %s counters got cyc=%0d stl=%0d want cyc=%0d stl=%0d",
                 e.name, cycle_count, stall_count, e.cyc, e.stl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mispredict();
    stim_t t[$];
    sb_t   e;
    t.push_back(mk("mp_with_halt", 0,0,0, 0,0,0, 0,1,1,0,0, O_MIS, M_ALL, 1,0));
    t.push_back(mk("mp_stay_run",  0,0,0, 0,0,0, 0,0,0,0,0, O_RUN, M_ALL, 1,0));
    t.push_back(mk("mp_over_lu",   0,0,1, 5,5,0, 0,0,1,0,0, O_MIS, M_ALL, 1,0));
    t.push_back(mk("run_start_ign",1,1,0, 0,0,0, 0,0,0,0,0, O_RUN, M_ALL, 1,0));
    t.push_back(mk("run_still",    0,0,0, 0,0,0, 0,0,0,0,0, O_RUN, M_ALL, 1,0));
    foreach (t[i]) begin
      apply(t[i]); push_exp(t[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ((outs() & e.msk) !== (e.exp & e.msk)) begin
        errors++;
        $display("FAIL %s ctrl got %b want %b mask %b", e.name, outs(), e.exp, e.msk);
      end
      checks++;
      if (cycle_count !== e.cyc || stall_count !== e.stl) begin
        errors++;
        $display("FAIL %s counters got cyc=%0d stl=%0d want cyc=%0d stl=%0d",
                 e.name, cycle_count, stall_count, e.cyc, e.stl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt_drain();
    stim_t t[$];
    sb_t   e;
    t.push_back(mk("hd_halt_id",   0,0,0, 0,0,0, 0,1,0,0,0, O_HALTID, M_HID,   1,0));
    t.push_back(mk("hd_d1_mis",    0,0,0, 0,0,0, 0,0,1,0,0, O_DRAIN,  M_DRAIN, 1,0));
    t.push_back(mk("hd_d2",        1,0,0, 0,0,0, 0,0,0,0,0, O_DRAIN,  M_DRAIN, 1,0));
    t.push_back(mk("hd_d3_wb",     0,0,0, 0,0,0, 0,0,0,1,0, O_DRAIN,  M_DRAIN, 1,0));
    t.push_back(mk("hd_halted",    0,0,0, 0,0,0, 0,0,0,0,0, O_HALTED, M_ALL,   0,0));
    t.push_back(mk("hd_start_ign", 1,0,0, 0,0,0, 0,0,0,0,0, O_HALTED, M_ALL,   0,0));
    t.push_back(mk("hd_stay",      0,0,0, 0,0,0, 0,0,0,0,0, O_HALTED, M_ALL,   0,0));
    foreach (t[i]) begin
      apply(t[i]); push_exp(t[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ((outs() & e.msk) !== (e.exp & e.msk)) begin
        errors++;
        $display("FAIL %s ctrl got %b want %b mask %b", e.name, outs(), e.exp, e.msk);
      end
      checks++;
      if (cycle_count !== e.cyc || stall_count !== e.stl) begin
        errors++;
        $display("FAIL %s counters got cyc=%0d stl=%0d want cyc=%0d stl=%0d",
                 e.name, cycle_count, stall_count, e.cyc, e.stl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_drain_timeout();
    stim_t t[$];
    sb_t   e;
    test_reset();
    t.push_back(mk("to_start", 1,0,0, 0,0,0, 0,0,0,0,0, O_IDLE,   M_ALL, 0,0));
    t.push_back(mk("to_halt",  0,0,0, 0,0,0, 0,1,0,0,0, O_HALTID, M_HID, 1,0));
    repeat (7) t.push_back(mk("to_drain", 0,0,0, 0,0,0, 0,0,0,0,0, O_DRAIN, M_DRAIN, 1,0));
    t.push_back(mk("to_err",   0,0,0, 0,0,0, 0,0,0,0,0, O_HERR,   M_ALL, 0,0));
    t.push_back(mk("to_hold",  1,0,0, 0,0,0, 0,0,0,1,0, O_HERR,   M_ALL, 0,0));
    foreach (t[i]) begin
      apply(t[i]); push_exp(t[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ((outs() & e.msk) !== (e.exp & e.msk)) begin
        errors++;
        $display("FAIL %s ctrl got %b want %b mask %b", e.name, outs(), e.exp, e.msk);
      end
      checks++;
      if (cycle_count !== e.cyc || stall_count !== e.stl) begin
        errors++;
        $display("FAIL %s counters got cyc=%0d stl=%0d want cyc=%0d stl=%0d",
                 e.name, cycle_count, stall_count, e.cyc, e.stl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_step();
    stim_t t[$];
    sb_t   e;
    test_reset();
    for (int p = 0; p < 3; p++) begin
      t.push_back(mk("st_start", 1,1,0, 0,0,0, 0,0,0,0,0, O_IDLE, M_ALL, 0,0));
      t.push_back(mk("st_step",  0,0,0, 0,0,0, 0,0,0,0,0, O_RUN,  M_ALL, 1,0));
      t.push_back(mk("st_idle",  0,0,0, 0,0,0, 0,0,0,0,0, O_IDLE, M_ALL, 0,0));
    end
    t.push_back(mk("st_start_lu", 1,1,0, 0,0,0, 0,0,0,0,0, O_IDLE,  M_ALL,   0,0));
    t.push_back(mk("st_stall",    0,0,1, 4,4,0, 0,0,0,0,0, O_STALL, M_STALL, 1,1));
    t.push_back(mk("st_consumed", 0,0,0, 0,0,0, 0,0,0,0,0, O_IDLE,  M_ALL,   0,0));
    foreach (t[i]) begin
      apply(t[i]); push_exp(t[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ((outs() & e.msk) !== (e.exp & e.msk)) begin
        errors++;
        $display("FAIL %s ctrl got %b want %b mask %b", e.name, outs(), e.exp, e.msk);
      end
      checks++;
      if (cycle_count !== e.cyc || stall_count !== e.stl) begin
        errors++;
        $display("FAIL %s counters got cyc=%0d stl=%0d want cyc=%0d stl=%0d",
                 e.name, cycle_count, stall_count, e.cyc, e.stl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_drain();
    stim_t t[$];
    sb_t   e;
    t.push_back(mk("rd_start",  1,0,0, 0,0,0, 0,0,0,0,0, O_IDLE,   M_ALL,   0,0));
    t.push_back(mk("rd_stall",  0,0,1, 6,6,0, 0,0,0,0,0, O_STALL,  M_STALL, 1,1));
    t.push_back(mk("rd_halt",   0,0,0, 0,0,0, 0,1,0,0,0, O_HALTID, M_HID,   1,0));
    t.push_back(mk("rd_d1",     0,0,0, 0,0,0, 0,0,0,0,0, O_DRAIN,  M_DRAIN, 1,0));
    t.push_back(mk("rd_reset",  1,0,0, 0,0,0, 0,0,0,1,1, O_DRAIN,  M_DRAIN, 0,0));
    t.push_back(mk("rd_idle",   0,0,0, 0,0,0, 0,0,0,0,0, O_IDLE,   M_ALL,   0,0));
    t.push_back(mk("rd_start2", 1,0,0, 0,0,0, 0,0,0,0,0, O_IDLE,   M_ALL,   0,0));
    t.push_back(mk("rd_halt2",  0,0,0, 0,0,0, 0,1,0,0,0, O_HALTID, M_HID,   1,0));
    repeat (7) t.push_back(mk("rd_drain", 0,0,0, 0,0,0, 0,0,0,0,0, O_DRAIN, M_DRAIN, 1,0));
    t.push_back(mk("rd_err",    0,0,0, 0,0,0, 0,0,0,0,0, O_HERR,   M_ALL,   0,0));
    foreach (t[i]) begin
      apply(t[i]); push_exp(t[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ((outs() & e.msk) !== (e.exp & e.msk)) begin
        errors++;
        $display("FAIL %s ctrl got %b want %b mask %b", e.name, outs(), e.exp, e.msk);
      end
      checks++;
      if (cycle_count !== e.cyc || stall_count !== e.stl) begin
        errors++;
        $display("FAIL %s counters got cyc=%0d stl=%0d want cyc=%0d stl=%0d",
                 e.name, cycle_count, stall_count, e.cyc, e.stl);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load_use();
    test_mispredict();
    test_halt_drain();
    test_drain_timeout();
    test_step();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
